// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter.
//   state_t : arbiter FSM states (IDLE / GRANT)
//   id_w(n) : width of an index that selects one of n requesters
// Optional feature macro used by the arbiter: FIFO_ARB_BURST_EN
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Index width for n requesters; kept at least 1 bit so a degenerate
  // single-entry instance still has a legal vector.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker. Scans last_i+1, last_i+2, ... modulo N
// and returns the first requester found.
// Ports:
//   req_i  [N-1:0]      request vector
//   last_i [IW-1:0]     most recently served index (lowest priority)
//   idx_o  [IW-1:0]     chosen index (0 when none)
//   any_o               at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req_i,
  input  logic [id_w(N)-1:0]  last_i,
  output logic [id_w(N)-1:0]  idx_o,
  output logic                any_o
);

  localparam int IW = id_w(N);

  logic [IW-1:0] pos;

  // Walk from the lowest priority slot up to the highest so that the last
  // assignment (closest to last_i+1) wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = IW'((int'(last_i) + 1 + k) % N);
      if (req_i[pos]) begin
        idx_o = pos;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the write port of one FIFO among NUM_REQ producers. Grants rotate
// round-robin and a grant holds for up to BURST_LEN accepted words. A word is
// written to the FIFO in the same cycle it is acknowledged.
// Optional feature macro: FIFO_ARB_BURST_EN
//   defined     : a grant holds for up to BURST_LEN words (cnt register built)
//   not defined : every write ends the grant (per-word round-robin), no cnt
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-requester valid
//   req_data     packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack          one-hot: word of requester i consumed this cycle
//   fifo_full    FIFO full flag (stalls the grant)
//   fifo_wren    FIFO write enable
//   fifo_wdata   FIFO write data (0 when not writing)
//   owner        current grant holder (valid while busy)
//   busy         grant active
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          fifo_full,
  output logic                          fifo_wren,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [id_w(NUM_REQ)-1:0]      owner,
  output logic                          busy
);

  localparam int IW = id_w(NUM_REQ);

  state_t        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q,  last_d;

  logic [NUM_REQ-1:0]    owner_oh;
  logic [DATA_WIDTH-1:0] word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
    assign owner_oh[gi] = (owner_q == IW'(gi));
    assign word[gi]     = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  logic in_grant, owner_req, write, burst_end, release_w;
  logic [NUM_REQ-1:0] pick_req;
  logic [IW-1:0]      pick_last, pick_idx;
  logic               pick_any;

  assign in_grant  = (state_q == GRANT);
  assign owner_req = |(req & owner_oh);
  assign write     = in_grant & owner_req & ~fifo_full;

`ifdef FIFO_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign burst_end = (cnt_q == CW'(BURST_LEN - 1));
`else
  // Burst length collapses to one word: every write closes the grant.
  localparam int BURST_EFF = BURST_LEN * 0 + 1;
  assign burst_end = (BURST_EFF == 1);
`endif

  // A stall (full FIFO) never releases; a withdrawn owner always does.
  assign release_w = in_grant & ((write & burst_end) | ~owner_req);

  // One picker serves both cases: from IDLE it rotates after last_q; on a
  // hand-over it rotates after the releasing owner, whose request is masked.
  assign pick_req  = in_grant ? (req & ~owner_oh) : req;
  assign pick_last = in_grant ? owner_q : last_q;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i  (pick_req),
    .last_i (pick_last),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
`ifdef FIFO_ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef FIFO_ARB_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          owner_d = pick_idx;
`ifdef FIFO_ARB_BURST_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
`ifdef FIFO_ARB_BURST_EN
        if (write) cnt_d = cnt_q + CW'(1);
`endif
        if (release_w) begin
          last_d = owner_q;
`ifdef FIFO_ARB_BURST_EN
          cnt_d  = '0;
`endif
          // Hand straight over to the next requester to avoid a dead cycle.
          if (pick_any) owner_d = pick_idx;
          else          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: all derived from registered state, so reset clears them at once.
  always_comb begin
    busy       = in_grant;
    owner      = owner_q;
    fifo_wren  = write;
    ack        = write ? owner_oh : '0;
    fifo_wdata = write ? word[owner_q] : '0;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Random producers and a depth-8 FIFO occupancy model drive the arbiter; a
// behavioural reference (grant holder / burst word count / last served)
// predicts every cycle's ack, write enable, write data, busy and owner.
// Honours FIFO_ARB_BURST_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
`ifdef FIFO_ARB_BURST_EN
  localparam int BLEN = 4;
`else
  localparam int BLEN = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      ack;
  logic              fifo_full = 1'b0;
  logic              fifo_wren;
  logic [DW-1:0]     fifo_wdata;
  logic [1:0]        owner;
  logic              busy;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wren  (fifo_wren),
    .fifo_wdata (fifo_wdata),
    .owner      (owner),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int m_holder;   // -1 when nobody holds the grant
  int m_last;
  int m_used;     // words written in the current grant
  int fcnt;       // FIFO occupancy

  logic [DW-1:0] pdata [N];
  int            rem   [N];
  int            n_writes = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_next(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pdata[i];
    fifo_full = (fcnt == DEPTH);
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_last   = N - 1;
    m_used   = 0;
  endtask

  // Asynchronous reset asserted between edges; outputs must drop immediately.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_wren",  32'(fifo_wren), 32'd0);
    check_eq("rst_ack",   32'(ack), 32'd0);
    check_eq("rst_wdata", 32'(fifo_wdata), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_owner", 32'(owner), 32'd0);
    check_eq("rst_busy2", 32'(busy), 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  task automatic run_cycle(input int rd_pct, input int go_pct);
    int nh, nu, nl;
    logic [N-1:0]  others;
    logic          w, rd;
    logic [N-1:0]  eack;
    logic [DW-1:0] edata;
    @(negedge clk);
    w = 1'b0; eack = '0; edata = '0;
    nh = m_holder; nu = m_used; nl = m_last;
    if (m_holder < 0) begin
      nh = rr_next(req, m_last);
      nu = 0;
    end else begin
      w = req[m_holder] && (fcnt < DEPTH);
      if (w) begin
        eack[m_holder] = 1'b1;
        edata = pdata[m_holder];
        nu = m_used + 1;
      end
      if (!req[m_holder] || (w && nu == BLEN)) begin
        nl = m_holder;
        others = req;
        others[m_holder] = 1'b0;
        nh = rr_next(others, m_holder);
        nu = 0;
      end
    end
    check_eq("busy",  32'(busy), 32'(m_holder >= 0));
    check_eq("wren",  32'(fifo_wren), 32'(w));
    check_eq("ack",   32'(ack), 32'(eack));
    check_eq("wdata", 32'(fifo_wdata), 32'(edata));
    if (m_holder >= 0) check_eq("owner", 32'(owner), 32'(m_holder));
    if (w) begin
      n_writes++;
      $display("write #%0d: req %0d data %h fifo_level %0d", n_writes, m_holder, edata, fcnt);
    end

    @(posedge clk);
    #1;
    m_holder = nh; m_used = nu; m_last = nl;
    rd   = (fcnt > 0) && ($urandom_range(99) < rd_pct);
    fcnt = fcnt + int'(w) - int'(rd);
    for (int i = 0; i < N; i++) begin
      if (eack[i]) begin
        rem[i]--;
        req[i] = 1'b0;
      end
      if (!req[i] && rem[i] == 0 && $urandom_range(99) < 3)
        rem[i] = 1 + $urandom_range(7);
      if (!req[i] && rem[i] > 0 && $urandom_range(99) < go_pct) begin
        req[i]   = 1'b1;
        pdata[i] = DW'($urandom);
      end
    end
    drive_inputs();
  endtask

  initial begin
    model_reset();
    fcnt = 0;
    for (int i = 0; i < N; i++) begin
      pdata[i] = '0;
      rem[i]   = 4;
    end
    drive_inputs();
    #3;
    check_eq("init_busy", 32'(busy), 32'd0);
    check_eq("init_wren", 32'(fifo_wren), 32'd0);
    check_eq("init_ack",  32'(ack), 32'd0);
    @(posedge clk);
    #1;
    check_eq("init_owner", 32'(owner), 32'd0);
    #2 rst_n = 1'b1;

    // Saturated phase: everybody requesting, FIFO drained every cycle.
    for (int c = 0; c < 40;  c++) run_cycle(100, 100);
    // Heavy back-pressure: FIFO fills and stalls grants.
    for (int c = 0; c < 300; c++) run_cycle(40, 60);
    do_reset();
    for (int c = 0; c < 300; c++) run_cycle(70, 50);
    do_reset();
    for (int c = 0; c < 200; c++) run_cycle(20, 90);
    for (int c = 0; c < 100; c++) run_cycle(100, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
